// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared types for the PWM feeder blocks.
//   slew_state_t : state encoding of the duty slewer FSM
//     S_IDLE      - waiting for a new target, target_ready high
//     S_RAMP_UP   - duty moving up one LSB per slew period
//     S_RAMP_DOWN - duty moving down one LSB per slew period
package pwm_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_RAMP_DOWN = 2'd2
    } slew_state_t;

endpackage

// File: rtl/step_prescaler.sv
// step_prescaler
//   Divides clk down to a one-cycle tick every DIV enabled cycles. Used here
//   to pace the duty slewer and standalone by other PWM users.
// Parameters
//   DIV   clk cycles per tick (>=1)
// Ports
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   ena   in   run enable; low holds the count and forces tick low
//   tick  out  registered one-cycle pulse, high the cycle after the count hits DIV-1
module step_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    output logic tick
);

    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Free-running count while enabled; the tick is registered off the
    // terminal count so it lines up with the wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (ena) begin
            tick  <= (count == LAST);
            count <= (count == LAST) ? '0 : count + CW'(1);
        end else begin
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_duty_slewer.sv
// pwm_duty_slewer
//   Upstream feeder for the PWM stage. Generates the PWM step tick and ramps
//   the duty output one LSB at a time toward a target accepted over a
//   valid/ready handshake, so loads never see a step change in duty.
// Parameters
//   N         duty width in bits (must match the PWM stage)
//   CLK_DIV   clk cycles per step pulse (>=1)
//   SLEW_DIV  step pulses per 1-LSB duty change (>=1)
// Ports
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   ena           in   run enable; low freezes prescaler and ramp
//   target        in   requested final duty
//   target_valid  in   target is valid this cycle
//   target_ready  out  high in IDLE only
//   step          out  one-cycle tick to the PWM step input
//   duty          out  current slewed duty
//   busy          out  high while ramping
//   done          out  one-cycle pulse when duty reaches the accepted target
module pwm_duty_slewer
    import pwm_pkg::*;
#(
    parameter int N        = 8,
    parameter int CLK_DIV  = 4,
    parameter int SLEW_DIV = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] target,
    input  logic         target_valid,
    output logic         target_ready,
    output logic         step,
    output logic [N-1:0] duty,
    output logic         busy,
    output logic         done
);

    localparam int SW = $clog2(SLEW_DIV + 1);
    localparam logic [SW-1:0] SLEW_LAST = SW'(SLEW_DIV - 1);

    slew_state_t   state, state_nxt;
    logic [N-1:0]  tgt_q, tgt_nxt;
    logic [N-1:0]  duty_nxt;
    logic [SW-1:0] slew_cnt, slew_nxt;
    logic          done_nxt;
    logic          tick;

    step_prescaler #(.DIV(CLK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .tick (tick)
    );

    assign step         = tick;
    assign target_ready = (state == S_IDLE);
    assign busy         = (state != S_IDLE);

    // Next-state and next-duty logic. The ramp only consumes a tick while
    // ena is high, so a tick registered just before ena drops cannot move
    // duty or the slew counter during the frozen period. Duty stops exactly
    // on tgt_q, which is what keeps it from ever wrapping.
    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_q;
        duty_nxt  = duty;
        slew_nxt  = slew_cnt;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (target_valid) begin
                    tgt_nxt  = target;
                    slew_nxt = '0;
                    if (target > duty) begin
                        state_nxt = S_RAMP_UP;
                    end else if (target < duty) begin
                        state_nxt = S_RAMP_DOWN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_RAMP_UP, S_RAMP_DOWN: begin
                if (ena && tick) begin
                    if (slew_cnt == SLEW_LAST) begin
                        slew_nxt = '0;
                        duty_nxt = (state == S_RAMP_UP) ? duty + N'(1) : duty - N'(1);
                        if (duty_nxt == tgt_q) begin
                            state_nxt = S_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        slew_nxt = slew_cnt + SW'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Single register block for all slewer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tgt_q    <= '0;
            duty     <= '0;
            slew_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tgt_q    <= tgt_nxt;
            duty     <= duty_nxt;
            slew_cnt <= slew_nxt;
            done     <= done_nxt;
        end
    end

endmodule
